// File: rtl/alu_issue_ctrl.sv
// Issue controller ahead of the combinational ALU: holds R0-R3, Reg_Y, Reg_R, Reg_Z,
// sequences each register-to-register instruction through LOAD/EXEC/WB and writes back.
module alu_issue_ctrl #(
  parameter int word_size = 8,
  parameter int op_size   = 4,
  parameter int sel_size  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [word_size-1:0] instr,
  input  logic                 ld_en,
  input  logic [sel_size-1:0]  ld_sel,
  input  logic [word_size-1:0] ld_data,
  input  logic [sel_size-1:0]  rd_sel,
  output logic [word_size-1:0] rd_data,
  output logic [word_size-1:0] alu_data_1,
  output logic [word_size-1:0] alu_data_2,
  output logic [op_size-1:0]   alu_sel,
  input  logic [word_size-1:0] alu_out,
  input  logic                 alu_zero_flag,
  output logic                 zero_flag,
  output logic                 done,
  output logic                 err
);

  localparam int num_regs = 1 << sel_size;

  localparam logic [op_size-1:0] OP_NOP = op_size'(0);
  localparam logic [op_size-1:0] OP_ADD = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB = op_size'(2);
  localparam logic [op_size-1:0] OP_AND = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT = op_size'(4);
  localparam logic [op_size-1:0] OP_EQZ = op_size'(9);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    WB
  } state_t;

  state_t state, next_state;

  logic [word_size-1:0] regs [num_regs];
  logic [word_size-1:0] reg_y;
  logic [word_size-1:0] reg_r;
  logic [word_size-1:0] ir;
  logic                 reg_z;
  logic                 done_q;
  logic                 err_q;

  logic [op_size-1:0]  in_op;
  logic [op_size-1:0]  ir_op;
  logic [sel_size-1:0] ir_src;
  logic [sel_size-1:0] ir_dst;

  logic accept;
  logic ld_we;

  assign in_op  = instr[2*sel_size +: op_size];
  assign ir_op  = ir[2*sel_size +: op_size];
  assign ir_src = ir[sel_size +: sel_size];
  assign ir_dst = ir[0 +: sel_size];

  function automatic logic is_alu_op(input logic [op_size-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_NOT) || (op == OP_EQZ);
  endfunction

  function automatic logic is_write_op(input logic [op_size-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // A load strobe in IDLE takes the cycle; a simultaneous instruction must be held.
  always_comb begin
    instr_ready = (state == IDLE) && !ld_en;
    accept      = instr_ready && instr_valid;
    ld_we       = (state == IDLE) && ld_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = is_alu_op(in_op) ? LOAD : WB;
      LOAD: next_state = EXEC;
      EXEC: next_state = WB;
      WB:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    alu_sel    = OP_NOP;
    alu_data_1 = reg_y;
    alu_data_2 = '0;
    if (state == EXEC) begin
      alu_sel    = ir_op;
      alu_data_2 = (ir_op == OP_NOT) ? regs[ir_src] : regs[ir_dst];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < num_regs; i++) regs[i] <= '0;
      reg_y  <= '0;
      reg_r  <= '0;
      ir     <= '0;
      reg_z  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (ld_we)  regs[ld_sel] <= ld_data;
      if (accept) ir <= instr;
      if (state == LOAD) reg_y <= regs[ir_src];
      if (state == EXEC) begin
        reg_r <= alu_out;
        reg_z <= alu_zero_flag;
      end
      if ((state == WB) && is_write_op(ir_op)) regs[ir_dst] <= reg_r;
      done_q <= (state == WB);
      err_q  <= (state == WB) && !is_alu_op(ir_op) && (ir_op != OP_NOP);
    end
  end

  assign rd_data   = regs[rd_sel];
  assign zero_flag = reg_z;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller directly upstream of the ALU. It accepts one register-to-register instruction at a time and holds the four-entry register file (R0–R3) plus Reg_Y. It drives the ALU operand and select inputs, then captures the ALU result and zero flag into Reg_R/Reg_Z. Finally it writes the result back to the destination register and signals completion. A sequencer feeds it; the ALU is a separate combinational instance wired to its `alu_*` ports.

## Interface
- `word_size`, 8, datapath and instruction width
- `op_size`, 4, opcode width (instr[7:4])
- `sel_size`, 2, register-select width (src = instr[3:2], dest = instr[1:0])
- `clk` input 1 rising-edge clock
- `rst` input 1 reset, asynchronous, active-high
- `instr_valid` input 1 instruction offered
- `instr_ready` output 1 block can accept this cycle
- `instr` input word_size {opcode, src, dest}
- `ld_en` input 1 direct register load strobe
- `ld_sel` input sel_size register to load
- `ld_data` input word_size load value
- `rd_sel` input sel_size debug read select
- `rd_data` output word_size R[rd_sel], combinational
- `alu_data_1` output word_size to ALU data_1 (Reg_Y)
- `alu_data_2` output word_size to ALU data_2 (Bus_1)
- `alu_sel` output op_size to ALU sel
- `alu_out` input word_size ALU result
- `alu_zero_flag` input 1 ALU zero flag
- `zero_flag` output 1 Reg_Z
- `done` output 1 one-cycle completion pulse
- `err` output 1 one-cycle illegal-opcode pulse

## Operation
- FSM states: IDLE, LOAD, EXEC, WB.
- IDLE:
  - `instr_ready = (state==IDLE) && !ld_en`.
  - On `instr_valid && instr_ready`, latch instr into IR.
  - Legal ALU opcodes go to LOAD. NOP (0000) and illegal opcodes go to WB.
- LOAD: Reg_Y <= R[src]; go to EXEC.
- EXEC:
  - `alu_sel` = IR opcode, `alu_data_1` = Reg_Y.
  - `alu_data_2` = R[src] for NOT, R[dest] otherwise.
  - On the edge, Reg_R <= alu_out and Reg_Z <= alu_zero_flag; go to WB.
- WB:
  - ADD/SUB/AND/NOT write R[dest] <= Reg_R.
  - EQZ writes nothing.
  - Go to IDLE.
  - `done` is registered high for exactly the cycle after the WB edge.
  - `err` is additionally high in that same cycle for illegal opcodes.
- Opcode semantics (carries dropped, all results mod 2^word_size):
  - ADD (0001): dest = src + dest.
  - SUB (0010): dest = dest − src.
  - AND (0011): dest = src & dest.
  - NOT (0100): dest = ~src.
  - EQZ (1001): Z = (dest == src), no write.
- Illegal opcodes: 0101–1000 and 1010–1111 (RD/WR/BR/BRZ belong to the top-level control unit).
- Illegal opcodes and NOP leave R0–R3, Reg_Y and Reg_Z unchanged.
- Outside EXEC:
  - `alu_sel` = 0000 (NOP).
  - `alu_data_1` = Reg_Y.
  - `alu_data_2` = 0.
  - ALU outputs are never captured.
- src == dest is legal: ADD R1,R1 doubles R1; NOT R2,R2 inverts in place.
- Load port:
  - Acts only in IDLE. R[ld_sel] <= ld_data on the edge.
  - `ld_en` outside IDLE is ignored.
  - `ld_en` wins over `instr_valid` in the same cycle; the instruction is not accepted and must be held.

## Timing
- Reset values: R0–R3, Reg_Y, Reg_R, IR = 0; Reg_Z = 0; state IDLE; `done` = `err` = 0.
  - `instr_ready` = 1 once `rst` is low (with `ld_en` low).
  - `alu_sel` = 0000.
- ALU instruction latency:
  - Accept edge T0, LOAD edge T1, EXEC edge T2 (Z updated), WB edge T3 (dest written).
  - `done` high in cycle T3..T4; `instr_ready` high in that same cycle.
  - Minimum issue interval: 4 cycles.
- NOP/illegal latency: accept T0, WB edge T1, `done`/`err` high in cycle T1..T2.
- `rd_data` reflects a write in the cycle after the writing edge.
- `rst` asserted in any state aborts immediately, with no partial writeback. All registers return to reset values asynchronously.

## Test plan
- Load R1=0x05 and R2=0x03, then issue instr 0x16 (ADD src R1, dest R2) → R2=0x08, zero_flag=0, one `done` pulse 4 cycles after accept.
- R2=0x08, R3=0x08, issue 0x2B (SUB src R2, dest R3) → R3=0x00, zero_flag=1; then R0=0xFF, R1=0x01, issue 0x01 (ADD src R0, dest R1) → R1=0x00 (wrap), zero_flag=1.
- R1=0x0F, issue 0x44 (NOT src R1, dest R0) → R0=0xF0, R1 still 0x0F; `alu_data_2` observed as 0x0F during EXEC.
- R2=0x3C, R3=0x3C, issue 0x9B (EQZ) → zero_flag=1, R3 unchanged; then 0x00 (NOP) → `done` 2 cycles after accept, zero_flag still 1, no register change.
- Issue 0x56 (RD) → `err` and `done` high together for one cycle 2 cycles after accept, all registers and zero_flag unchanged.
- Assert `ld_en` (R1←0xAA) together with `instr_valid` (0x16) in IDLE → R1=0xAA and instruction not accepted; then assert `rst` during EXEC of that ADD → R2 not written, all registers 0, `instr_ready` high after `rst` release.
